alu_fun_issuer: RTL and testbench
=================================

ALU_FUN_ISSUER -- requirements
Module: alu_fun_issuer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum ISSUE cycles spent waiting for ALU_Ready (legal range 2..255).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port Arith_Req, input, 1 bit: arithmetic unit requests an issue, level, held until granted.
REQ-005 The block SHALL have port Logic_Req, input, 1 bit: logic unit request, same rules as Arith_Req.
REQ-006 The block SHALL have port CMP_Req, input, 1 bit: compare unit request, same rules.
REQ-007 The block SHALL have port Shift_Req, input, 1 bit: shift unit request, same rules.
REQ-008 The block SHALL have port ALU_Ready, input, 1 bit: downstream decoder/ALU accepts the current code.
REQ-009 The block SHALL have port ALU_FUN, output, 2 bits: registered operation-class code: 00 Arith, 01 Logic, 10 CMP, 11 Shift.
REQ-010 The block SHALL have port ALU_FUN_Valid, output, 1 bit: ALU_FUN holds a valid code.
REQ-011 The block SHALL have port Arith_Grant, Logic_Grant, CMP_Grant, Shift_Grant, outputs, 1 bit each: one-cycle pulse confirming transfer for that requester.
REQ-012 The block SHALL have port Busy, output, 1 bit: high whenever the FSM is in ISSUE.
REQ-013 The block SHALL have port Timeout_Err, output, 1 bit: sticky flag set on a timed-out issue.
REQ-014 The block SHALL have port Issue_Count, output, 8 bits: count of completed transfers.

Function
REQ-015 The FSM SHALL have two states, IDLE and ISSUE.
REQ-016 In IDLE with no request high, the FSM SHALL stay in IDLE with ALU_FUN_Valid=0.
REQ-017 In IDLE with any request high at edge N, the block SHALL latch the round-robin winner's code into ALU_FUN and enter ISSUE, with ALU_FUN_Valid=1 from edge N (one-cycle latency).
REQ-018 Arbitration SHALL be round-robin over order Arith, Logic, CMP, Shift starting at a priority pointer; after unit k finishes (transfer or timeout), the pointer SHALL become (k+1) mod 4.
REQ-019 Requests SHALL be sampled only in IDLE; request changes during ISSUE SHALL NOT alter ALU_FUN.
REQ-020 A transfer SHALL occur at a rising edge where state=ISSUE, ALU_FUN_Valid=1 and ALU_Ready=1.
REQ-021 On a transfer, the block SHALL return to IDLE, clear ALU_FUN_Valid, pulse exactly one Grant high for the following cycle, and increment Issue_Count (255 wraps to 0).
REQ-022 Consecutive issues SHALL be separated by at least one IDLE cycle; maximum throughput is one transfer per two cycles.
REQ-023 A wait counter SHALL clear on entering ISSUE and increment every ISSUE cycle with ALU_Ready=0.
REQ-024 When the wait counter reaches TIMEOUT-1 with ALU_Ready still 0, at the next edge the block SHALL abort to IDLE, clear ALU_FUN_Valid, set Timeout_Err, advance the pointer, issue no Grant and leave Issue_Count unchanged.
REQ-025 If ALU_Ready=1 on the same edge that the timeout would fire, the transfer SHALL win: no error and a normal grant.
REQ-026 ALU_FUN SHALL hold its last value while ALU_FUN_Valid=0.
REQ-027 At most one Grant SHALL be high in any cycle.

Reset
REQ-028 With RST=1 at a rising edge, the block SHALL force: state IDLE, pointer Arith, ALU_FUN=00, ALU_FUN_Valid=0, all Grants=0, Busy=0, Timeout_Err=0, Issue_Count=0, wait counter=0.
REQ-029 RST SHALL override every other event, including an in-flight ISSUE or a simultaneous transfer: no grant is produced and the count is not incremented.
REQ-030 Timeout_Err SHALL be cleared only by RST.

Verification
REQ-031 Single request: Logic_Req=1 and ALU_Ready=1 -> ALU_FUN=01, Valid high for 1 cycle, Logic_Grant pulses once, Issue_Count=1.
REQ-032 All four requests held and ALU_Ready=1 -> grant order Arith, Logic, CMP, Shift, Arith; ALU_FUN sequence 00,01,10,11,00; Issue_Count=5.
REQ-033 Backpressure: CMP_Req=1, ALU_Ready low for 5 cycles then high -> ALU_FUN=10 stable with Valid high for 6 cycles, then a single CMP_Grant.
REQ-034 Timeout: Shift_Req=1, ALU_Ready=0, TIMEOUT=16 -> Valid drops after 16 ISSUE cycles; Timeout_Err=1; no grant; pointer moves to Arith.
REQ-035 Reset mid-ISSUE: RST asserted while Valid=1 and ALU_Ready=1 -> no grant; all outputs return to reset values.
REQ-036 Wrap: 256 transfers -> Issue_Count returns to 0.

Source files
------------

// File: rtl/alu_fun_issuer.sv
// Round-robin issuer of ALU operation-class codes to a downstream decoder.
// Holds one code at a time until accepted or until the wait budget runs out.
module alu_fun_issuer #(
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Arith_Req,
  input  logic       Logic_Req,
  input  logic       CMP_Req,
  input  logic       Shift_Req,
  input  logic       ALU_Ready,
  output logic [1:0] ALU_FUN,
  output logic       ALU_FUN_Valid,
  output logic       Arith_Grant,
  output logic       Logic_Grant,
  output logic       CMP_Grant,
  output logic       Shift_Grant,
  output logic       Busy,
  output logic       Timeout_Err,
  output logic [7:0] Issue_Count,
  output logic       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where ALU_FUN_Valid and
  // ALU_Ready are both high; once raised, Valid and ALU_FUN stay stable until
  // that transfer or a timeout abort.

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] fun_q;
  logic       valid_q;
  logic [3:0] grant_q;
  logic       err_q;
  logic [7:0] cnt_q;
  logic [7:0] wait_q;

  logic [3:0] req;
  logic [1:0] fun_d;
  logic [1:0] rr_idx;
  logic       found;

  assign req = {Shift_Req, CMP_Req, Logic_Req, Arith_Req};

  // First requester at or after the priority pointer, wrapping around.
  always_comb begin
    fun_d  = ptr_q;
    rr_idx = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = ptr_q + 2'(i);
      if (!found && req[rr_idx]) begin
        fun_d = rr_idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      fun_q   <= 2'd0;
      valid_q <= 1'b0;
      grant_q <= 4'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      wait_q  <= 8'd0;
    end else begin
      grant_q <= 4'd0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            fun_q   <= fun_d;
            valid_q <= 1'b1;
            wait_q  <= 8'd0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (ALU_Ready) begin
            state_q        <= IDLE;
            valid_q        <= 1'b0;
            grant_q[fun_q] <= 1'b1;
            cnt_q          <= cnt_q + 8'd1;
            ptr_q          <= fun_q + 2'd1;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            ptr_q   <= fun_q + 2'd1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ALU_FUN       = fun_q;
  assign ALU_FUN_Valid = valid_q;
  assign Arith_Grant   = grant_q[0];
  assign Logic_Grant   = grant_q[1];
  assign CMP_Grant     = grant_q[2];
  assign Shift_Grant   = grant_q[3];
  assign Busy          = (state_q == ISSUE);
  assign Timeout_Err   = err_q;
  assign Issue_Count   = cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_fun_issuer.sv
// Directed bench for alu_fun_issuer: round-robin order, backpressure,
// timeout, reset override and counter wrap, all checked at falling edges.
module tb_alu_fun_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       arith_req, logic_req, cmp_req, shift_req, alu_ready;
  logic [1:0] alu_fun;
  logic       alu_fun_valid;
  logic       arith_grant, logic_grant, cmp_grant, shift_grant;
  logic       busy, timeout_err, dbg_state;
  logic [7:0] issue_count;
  logic [3:0] gnt;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic [1:0] e;
  logic [3:0] e_gnt;

  always #5 clk = ~clk;

  assign gnt = {shift_grant, cmp_grant, logic_grant, arith_grant};

  alu_fun_issuer #(.TIMEOUT(16)) dut (
    .CLK           (clk),
    .RST           (rst),
    .Arith_Req     (arith_req),
    .Logic_Req     (logic_req),
    .CMP_Req       (cmp_req),
    .Shift_Req     (shift_req),
    .ALU_Ready     (alu_ready),
    .ALU_FUN       (alu_fun),
    .ALU_FUN_Valid (alu_fun_valid),
    .Arith_Grant   (arith_grant),
    .Logic_Grant   (logic_grant),
    .CMP_Grant     (cmp_grant),
    .Shift_Grant   (shift_grant),
    .Busy          (busy),
    .Timeout_Err   (timeout_err),
    .Issue_Count   (issue_count),
    .dbg_state_o   (dbg_state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    arith_req = 1'b0; logic_req = 1'b0; cmp_req = 1'b0; shift_req = 1'b0;
    alu_ready = 1'b0;
    step(); step();
    chk("rst_fun",   8'(alu_fun), 8'h0);
    chk("rst_valid", 8'(alu_fun_valid), 8'h0);
    chk("rst_gnt",   8'(gnt), 8'h0);
    chk("rst_busy",  8'(busy), 8'h0);
    chk("rst_err",   8'(timeout_err), 8'h0);
    chk("rst_count", issue_count, 8'h0);
    chk("rst_state", 8'(dbg_state), 8'h0);
    rst = 1'b0;
    step();
    chk("idle_valid", 8'(alu_fun_valid), 8'h0);

    // All four held: Arith, Logic, CMP, Shift, Arith
    arith_req = 1'b1; logic_req = 1'b1; cmp_req = 1'b1; shift_req = 1'b1;
    alu_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      e_gnt = 4'b0001 << e;
      step();
      chk("rr_valid", 8'(alu_fun_valid), 8'h1);
      chk("rr_fun",   8'(alu_fun), 8'(e));
      chk("rr_busy",  8'(busy), 8'h1);
      step();
      chk("rr_gnt",       8'(gnt), 8'(e_gnt));
      chk("rr_valid_low", 8'(alu_fun_valid), 8'h0);
    end
    chk("rr_count", issue_count, 8'd5);
    arith_req = 1'b0; logic_req = 1'b0; cmp_req = 1'b0; shift_req = 1'b0;
    step();
    chk("rr_gnt_clear", 8'(gnt), 8'h0);
    chk("rr_fun_hold",  8'(alu_fun), 8'h0);

    // Single Logic request
    logic_req = 1'b1;
    step();
    chk("single_valid", 8'(alu_fun_valid), 8'h1);
    chk("single_fun",   8'(alu_fun), 8'h1);
    step();
    chk("single_gnt",   8'(gnt), 8'b0010);
    chk("single_valid_low", 8'(alu_fun_valid), 8'h0);
    chk("single_count", issue_count, 8'd6);
    logic_req = 1'b0;
    step();
    chk("single_gnt_clear", 8'(gnt), 8'h0);

    // Ready on the same edge the timeout would fire: transfer wins
    alu_ready = 1'b0; logic_req = 1'b1;
    step();
    chk("race_fun", 8'(alu_fun), 8'h1);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("race_valid", 8'(alu_fun_valid), 8'h1);
    end
    alu_ready = 1'b1;
    step();
    chk("race_gnt",   8'(gnt), 8'b0010);
    chk("race_err",   8'(timeout_err), 8'h0);
    chk("race_count", issue_count, 8'd7);
    logic_req = 1'b0;
    step();

    // CMP backpressure, other requests toggling while in ISSUE
    alu_ready = 1'b0; cmp_req = 1'b1;
    step();
    chk("bp_valid", 8'(alu_fun_valid), 8'h1);
    chk("bp_fun",   8'(alu_fun), 8'h2);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) shift_req = 1'b1;
      if (k == 3) shift_req = 1'b0;
      step();
      chk("bp_valid_hold", 8'(alu_fun_valid), 8'h1);
      chk("bp_fun_hold",   8'(alu_fun), 8'h2);
      chk("bp_no_gnt",     8'(gnt), 8'h0);
    end
    alu_ready = 1'b1;
    step();
    chk("bp_gnt",   8'(gnt), 8'b0100);
    chk("bp_count", issue_count, 8'd8);
    cmp_req = 1'b0;
    step();

    // Shift timeout after 16 ISSUE cycles
    alu_ready = 1'b0; shift_req = 1'b1;
    step();
    chk("to_valid", 8'(alu_fun_valid), 8'h1);
    chk("to_fun",   8'(alu_fun), 8'h3);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("to_valid_hold", 8'(alu_fun_valid), 8'h1);
      chk("to_no_gnt",     8'(gnt), 8'h0);
    end
    step();
    chk("to_valid_low", 8'(alu_fun_valid), 8'h0);
    chk("to_err",       8'(timeout_err), 8'h1);
    chk("to_gnt",       8'(gnt), 8'h0);
    chk("to_count",     issue_count, 8'd8);
    chk("to_busy",      8'(busy), 8'h0);
    shift_req = 1'b0;
    step();
    chk("to_gnt_after", 8'(gnt), 8'h0);
    chk("to_err_sticky", 8'(timeout_err), 8'h1);

    // Pointer moved to Arith after the Shift timeout
    arith_req = 1'b1; logic_req = 1'b1; cmp_req = 1'b1; shift_req = 1'b1;
    alu_ready = 1'b1;
    step();
    chk("ptr_fun", 8'(alu_fun), 8'h0);
    arith_req = 1'b0; logic_req = 1'b0; cmp_req = 1'b0; shift_req = 1'b0;
    step();
    chk("ptr_gnt",   8'(gnt), 8'b0001);
    chk("ptr_count", issue_count, 8'd9);
    step();

    // Reset while an issue is in flight and ready is high
    logic_req = 1'b1; alu_ready = 1'b1;
    step();
    chk("mid_valid", 8'(alu_fun_valid), 8'h1);
    rst = 1'b1;
    step();
    chk("mid_gnt",   8'(gnt), 8'h0);
    chk("mid_valid_low", 8'(alu_fun_valid), 8'h0);
    chk("mid_count", issue_count, 8'h0);
    chk("mid_err",   8'(timeout_err), 8'h0);
    chk("mid_busy",  8'(busy), 8'h0);
    chk("mid_fun",   8'(alu_fun), 8'h0);
    rst = 1'b0; logic_req = 1'b0;
    step();
    chk("mid_gnt_after", 8'(gnt), 8'h0);

    // 256 transfers wrap the count back to zero
    arith_req = 1'b1; alu_ready = 1'b1;
    for (int k = 0; k < 255; k++) begin
      step(); step();
    end
    chk("wrap_255", issue_count, 8'd255);
    step(); step();
    chk("wrap_0",   issue_count, 8'd0);
    chk("wrap_gnt", 8'(gnt), 8'b0001);
    arith_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
